// File: rtl/hazard_controller_pkg.sv
// Shared encodings and control bundles for the pipeline hazard controller.
// Imported by the controller, its detector and the interface users.
package hazard_controller_pkg;

    localparam logic [1:0] RUN         = 2'd0;
    localparam logic [1:0] MEM_WAIT    = 2'd1;
    localparam logic [1:0] MULDIV_BUSY = 2'd2;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic fetch_stall;
        logic decode_stall;
        logic execute_stall;
        logic memory_stall;
        logic decode_flush;
        logic execute_bubble;
        logic memory_bubble;
        logic writeback_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    localparam ctrl_t CTRL_FREEZE = '{
        fetch_stall:      1'b1,
        decode_stall:     1'b1,
        execute_stall:    1'b1,
        memory_stall:     1'b1,
        writeback_bubble: 1'b1,
        default:          1'b0
    };

    localparam ctrl_t CTRL_MULDIV = '{
        fetch_stall:   1'b1,
        decode_stall:  1'b1,
        execute_stall: 1'b1,
        memory_bubble: 1'b1,
        default:       1'b0
    };

    localparam ctrl_t CTRL_BRANCH = '{
        decode_flush:   1'b1,
        execute_bubble: 1'b1,
        default:        1'b0
    };

    localparam ctrl_t CTRL_LOAD_USE = '{
        fetch_stall:    1'b1,
        decode_stall:   1'b1,
        execute_bubble: 1'b1,
        default:        1'b0
    };

    function automatic logic reg_match(
        input logic [4:0] src,
        input logic       used,
        input logic [4:0] dst
    );
        return used && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-to-hazard-controller bundle: stage hazard inputs and
// the stall/flush/bubble controls returned to the stage registers.
interface hazard_controller_if #(
    parameter int COUNTER_WIDTH = 32
);

    logic [4:0] decode_register_number_a;
    logic [4:0] decode_register_number_b;
    logic       decode_read_a;
    logic       decode_read_b;
    logic [4:0] execute_destination_register_number;
    logic       execute_is_load;
    logic       execute_branch_taken;
    logic       execute_muldiv_start;
    logic       memory_access_request;
    logic       memory_access_ready;

    logic fetch_stall;
    logic decode_stall;
    logic execute_stall;
    logic memory_stall;
    logic decode_flush;
    logic execute_bubble;
    logic memory_bubble;
    logic writeback_bubble;
    logic memory_timeout;
    logic [COUNTER_WIDTH-1:0] stall_cycle_count;

    modport master (
        output decode_register_number_a,
        output decode_register_number_b,
        output decode_read_a,
        output decode_read_b,
        output execute_destination_register_number,
        output execute_is_load,
        output execute_branch_taken,
        output execute_muldiv_start,
        output memory_access_request,
        output memory_access_ready,
        input  fetch_stall,
        input  decode_stall,
        input  execute_stall,
        input  memory_stall,
        input  decode_flush,
        input  execute_bubble,
        input  memory_bubble,
        input  writeback_bubble,
        input  memory_timeout,
        input  stall_cycle_count
    );

    modport slave (
        input  decode_register_number_a,
        input  decode_register_number_b,
        input  decode_read_a,
        input  decode_read_b,
        input  execute_destination_register_number,
        input  execute_is_load,
        input  execute_branch_taken,
        input  execute_muldiv_start,
        input  memory_access_request,
        input  memory_access_ready,
        output fetch_stall,
        output decode_stall,
        output execute_stall,
        output memory_stall,
        output decode_flush,
        output execute_bubble,
        output memory_bubble,
        output writeback_bubble,
        output memory_timeout,
        output stall_cycle_count
    );

endinterface

// File: rtl/hazard_controller_load_use_detector.sv
// Flags a decode source operand that needs the value of the load
// currently in execute; x0 never creates a dependency.
module load_use_detector
    import hazard_controller_pkg::*;
(
    input  logic [4:0] decode_register_number_a,
    input  logic [4:0] decode_register_number_b,
    input  logic       decode_read_a,
    input  logic       decode_read_b,
    input  logic [4:0] execute_destination_register_number,
    input  logic       execute_is_load,
    output logic       hazard
);

    logic dst_live;
    logic match_a;
    logic match_b;

    assign dst_live = execute_is_load &&
        (execute_destination_register_number != 5'd0);

    assign match_a = reg_match(
        decode_register_number_a,
        decode_read_a,
        execute_destination_register_number
    );

    assign match_b = reg_match(
        decode_register_number_b,
        decode_read_b,
        execute_destination_register_number
    );

    assign hazard = dst_live && (match_a || match_b);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline stall/flush sequencer: memory freeze, mul/div occupancy,
// branch redirect and load-use interlock, plus stall statistics.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int MULDIV_LATENCY = 4,
    parameter int MEM_TIMEOUT    = 64,
    parameter int COUNTER_WIDTH  = 32
) (
    input logic               clk,
    input logic               reset,
    hazard_controller_if.slave hz
);

    localparam int BW = $clog2(MULDIV_LATENCY + 1);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    logic [1:0]               state;
    logic [1:0]               state_next;
    logic [BW-1:0]            busy_count;
    logic [WW-1:0]            wait_count;
    logic                     muldiv_release;
    logic                     timeout_q;
    logic [COUNTER_WIDTH-1:0] stall_count;

    logic  load_use;
    logic  busy;
    logic  freeze;
    logic  issue;
    logic  busy_last;
    ctrl_t ctrl_raw;
    ctrl_t ctrl;

    load_use_detector u_load_use (
        .decode_register_number_a (hz.decode_register_number_a),
        .decode_register_number_b (hz.decode_register_number_b),
        .decode_read_a            (hz.decode_read_a),
        .decode_read_b            (hz.decode_read_b),
        .execute_destination_register_number
            (hz.execute_destination_register_number),
        .execute_is_load          (hz.execute_is_load),
        .hazard                   (load_use)
    );

    assign busy      = (state == MULDIV_BUSY);
    assign busy_last = busy && (busy_count == BW'(1));

    assign freeze = !busy &&
        hz.memory_access_request &&
        !hz.memory_access_ready;

    // The release cycle of MEM_WAIT is an ordinary advancing cycle.
    assign issue = !busy && !freeze &&
        hz.execute_muldiv_start && !muldiv_release;

    always_comb begin
        ctrl_raw = CTRL_NONE;
        if (busy || issue) begin
            ctrl_raw = CTRL_MULDIV;
        end else if (freeze) begin
            ctrl_raw = CTRL_FREEZE;
        end else if (hz.execute_branch_taken) begin
            ctrl_raw = CTRL_BRANCH;
        end else if (load_use) begin
            ctrl_raw = CTRL_LOAD_USE;
        end
        ctrl = reset ? CTRL_NONE : ctrl_raw;
    end

    always_comb begin
        state_next = RUN;
        if (busy) begin
            state_next = busy_last ? RUN : MULDIV_BUSY;
        end else if (freeze) begin
            state_next = MEM_WAIT;
        end else if (issue) begin
            state_next = MULDIV_BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            busy_count     <= '0;
            wait_count     <= '0;
            muldiv_release <= 1'b0;
            timeout_q      <= 1'b0;
            stall_count    <= '0;
        end else begin
            state          <= state_next;
            muldiv_release <= busy_last;

            if (issue) begin
                busy_count <= BW'(MULDIV_LATENCY - 2);
            end else if (busy) begin
                busy_count <= busy_count - BW'(1);
            end

            if (!freeze) begin
                wait_count <= '0;
            end else if (wait_count != WW'(MEM_TIMEOUT)) begin
                wait_count <= wait_count + WW'(1);
            end

            if (freeze && wait_count == WW'(MEM_TIMEOUT - 1)) begin
                timeout_q <= 1'b1;
            end

            if (ctrl.fetch_stall && stall_count != '1) begin
                stall_count <= stall_count + COUNTER_WIDTH'(1);
            end
        end
    end

    assign hz.fetch_stall       = ctrl.fetch_stall;
    assign hz.decode_stall      = ctrl.decode_stall;
    assign hz.execute_stall     = ctrl.execute_stall;
    assign hz.memory_stall      = ctrl.memory_stall;
    assign hz.decode_flush      = ctrl.decode_flush;
    assign hz.execute_bubble    = ctrl.execute_bubble;
    assign hz.memory_bubble     = ctrl.memory_bubble;
    assign hz.writeback_bubble  = ctrl.writeback_bubble;
    assign hz.memory_timeout    = timeout_q;
    assign hz.stall_cycle_count = stall_count;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios with
// literal expectations plus randomized traffic against a cycle model.
module tb_hazard_controller;

    localparam int LAT = 4;
    localparam int TMO = 64;
    localparam int CW  = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    hazard_controller_if #(.COUNTER_WIDTH(CW)) hz ();

    hazard_controller #(
        .MULDIV_LATENCY (LAT),
        .MEM_TIMEOUT    (TMO),
        .COUNTER_WIDTH  (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: time-based view of the pipeline's hazard obligations.
    int cyc       = 0;
    int issue_at  = -1000;
    int frz_run   = 0;
    bit m_timeout = 1'b0;
    int m_count   = 0;

    logic [7:0]    s_ctrl;
    logic          s_tmo;
    logic [CW-1:0] s_cnt;

    function automatic void check(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h cycle=%0d",
                     name, act, exp, cyc);
        end
    endfunction

    task automatic idle_inputs();
        hz.decode_register_number_a = 5'd0;
        hz.decode_register_number_b = 5'd0;
        hz.decode_read_a = 1'b0;
        hz.decode_read_b = 1'b0;
        hz.execute_destination_register_number = 5'd0;
        hz.execute_is_load = 1'b0;
        hz.execute_branch_taken = 1'b0;
        hz.execute_muldiv_start = 1'b0;
        hz.memory_access_request = 1'b0;
        hz.memory_access_ready = 1'b1;
    endtask

    // Called just after a posedge with inputs applied; compares at
    // the negedge, then advances the model across the next posedge.
    task automatic cycle();
        logic [7:0] e;
        bit busy, mask, frz, iss, lu;
        logic [4:0] rd;
        #4;
        rd   = hz.execute_destination_register_number;
        busy = (cyc > issue_at) && (cyc < issue_at + LAT - 1);
        mask = (cyc == issue_at + LAT - 1);
        frz  = !busy && hz.memory_access_request &&
               !hz.memory_access_ready;
        iss  = !busy && !frz && hz.execute_muldiv_start && !mask;
        lu   = hz.execute_is_load && rd != 5'd0 &&
               ((hz.decode_read_a && hz.decode_register_number_a == rd) ||
                (hz.decode_read_b && hz.decode_register_number_b == rd));
        if (reset)                        e = 8'b0000_0000;
        else if (busy || iss)             e = 8'b1110_0010;
        else if (frz)                     e = 8'b1111_0001;
        else if (hz.execute_branch_taken) e = 8'b0000_1100;
        else if (lu)                      e = 8'b1100_0100;
        else                              e = 8'b0000_0000;
        s_ctrl = {hz.fetch_stall, hz.decode_stall, hz.execute_stall,
                  hz.memory_stall, hz.decode_flush, hz.execute_bubble,
                  hz.memory_bubble, hz.writeback_bubble};
        s_tmo = hz.memory_timeout;
        s_cnt = hz.stall_cycle_count;
        check("ctrl", 32'(s_ctrl), 32'(e));
        check("timeout", 32'(s_tmo), 32'(m_timeout));
        check("stall_count", 32'(s_cnt), 32'(m_count));
        @(posedge clk);
        if (reset) begin
            issue_at  = -1000;
            frz_run   = 0;
            m_timeout = 1'b0;
            m_count   = 0;
        end else begin
            if (iss) issue_at = cyc;
            frz_run = frz ? frz_run + 1 : 0;
            if (frz_run >= TMO) m_timeout = 1'b1;
            if (e[7] && m_count < (1 << CW) - 1) m_count++;
        end
        cyc++;
        #1;
    endtask

    logic exp_es [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        idle_inputs();
        reset = 1'b1;
        hz.execute_muldiv_start = 1'b1;
        hz.memory_access_request = 1'b1;
        hz.memory_access_ready = 1'b0;
        @(posedge clk);
        #1;
        cycle();
        check("reset_ctrl", 32'(s_ctrl), 32'h0);
        cycle();
        check("reset_count", 32'(s_cnt), 32'h0);

        // Load-use through rs2, then execute holds a bubble.
        reset = 1'b0;
        idle_inputs();
        hz.execute_is_load = 1'b1;
        hz.execute_destination_register_number = 5'd5;
        hz.decode_register_number_b = 5'd5;
        hz.decode_read_b = 1'b1;
        cycle();
        check("lu_stall", 32'(s_ctrl), 32'hC4);
        hz.execute_is_load = 1'b0;
        cycle();
        check("lu_once", 32'(s_ctrl), 32'h00);
        hz.execute_is_load = 1'b1;
        hz.execute_destination_register_number = 5'd0;
        hz.decode_register_number_b = 5'd0;
        cycle();
        check("lu_x0", 32'(s_ctrl), 32'h00);

        // Three-cycle memory wait.
        idle_inputs();
        hz.memory_access_request = 1'b1;
        hz.memory_access_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("mem_freeze", 32'(s_ctrl), 32'hF1);
        end
        hz.memory_access_ready = 1'b1;
        cycle();
        check("mem_release", 32'(s_ctrl), 32'h00);
        check("mem_count", 32'(s_cnt), 32'd4);

        // Mul/div with start held high throughout.
        idle_inputs();
        hz.execute_muldiv_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("md_ex_stall", 32'(s_ctrl[5]), 32'(exp_es[i]));
            check("md_mem_bub", 32'(s_ctrl[1]), 32'(exp_es[i]));
        end
        hz.execute_muldiv_start = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // Branch wins over a simultaneous load-use match.
        hz.execute_branch_taken = 1'b1;
        hz.execute_is_load = 1'b1;
        hz.execute_destination_register_number = 5'd7;
        hz.decode_register_number_a = 5'd7;
        hz.decode_read_a = 1'b1;
        cycle();
        check("br_over_lu", 32'(s_ctrl), 32'h0C);

        // Long memory wait raises the sticky timeout.
        idle_inputs();
        hz.memory_access_request = 1'b1;
        hz.memory_access_ready = 1'b0;
        for (int i = 0; i < 70; i++) begin
            cycle();
            if (i == 63) check("tmo_before", 32'(s_tmo), 32'h0);
            if (i == 64) check("tmo_after", 32'(s_tmo), 32'h1);
        end
        hz.memory_access_ready = 1'b1;
        cycle();
        hz.memory_access_request = 1'b0;
        cycle();
        check("tmo_sticky", 32'(s_tmo), 32'h1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        check("tmo_cleared", 32'(s_tmo), 32'h0);

        // Reset on the final busy cycle leaves no release mask.
        hz.execute_muldiv_start = 1'b1;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        check("rst_busy_ctrl", 32'(s_ctrl), 32'h00);
        reset = 1'b0;
        hz.execute_muldiv_start = 1'b0;
        cycle();
        check("rst_run_ctrl", 32'(s_ctrl), 32'h00);
        check("rst_run_cnt", 32'(s_cnt), 32'h0);
        hz.execute_muldiv_start = 1'b1;
        cycle();
        check("rst_no_mask", 32'(s_ctrl), 32'hE2);
        hz.execute_muldiv_start = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // Randomized traffic; the counter saturates along the way.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            hz.decode_register_number_a = 5'($urandom_range(0, 7));
            hz.decode_register_number_b = 5'($urandom_range(0, 7));
            hz.decode_read_a = 1'($urandom_range(0, 1));
            hz.decode_read_b = 1'($urandom_range(0, 1));
            hz.execute_destination_register_number =
                5'($urandom_range(0, 7));
            hz.execute_is_load = ($urandom_range(0, 2) == 0);
            hz.execute_branch_taken = ($urandom_range(0, 7) == 0);
            hz.execute_muldiv_start = ($urandom_range(0, 7) == 0);
            hz.memory_access_request = ($urandom_range(0, 3) == 0);
            hz.memory_access_ready = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline control unit for the 5-stage RISC-V core. It sequences stalls, bubbles and flushes so the operand forwarding network only sees hazards it can resolve.
- Handles four cases: load-use hazards, data-memory wait states, fixed-latency multiply/divide occupancy in execute, and taken-branch redirects.
- Sits beside the forwarding unit. Its outputs drive stage-register enables and NOP-injection muxes.

Parameters:
- MULDIV_LATENCY, 4, total cycles a mul/div instruction occupies execute (legal range ≥3).
- MEM_TIMEOUT, 64, consecutive wait cycles before memory_timeout is raised.
- COUNTER_WIDTH, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- decode_register_number_a  in  5  rs1 of decode instruction.
- decode_register_number_b  in  5  rs2 of decode instruction.
- decode_read_a  in  1  decode instruction actually reads rs1.
- decode_read_b  in  1  decode instruction actually reads rs2.
- execute_destination_register_number  in  5  rd of execute instruction.
- execute_is_load  in  1  execute instruction is a load.
- execute_branch_taken  in  1  execute resolved a taken branch/jump.
- execute_muldiv_start  in  1  execute holds a mul/div instruction.
- memory_access_request  in  1  memory stage performing a data access.
- memory_access_ready  in  1  data memory completes the access this cycle.
- fetch_stall, decode_stall, execute_stall, memory_stall  out  1 each  hold the stage register.
- decode_flush  out  1  replace the decode register contents with a NOP.
- execute_bubble, memory_bubble, writeback_bubble  out  1 each  inject a NOP into that stage.
- memory_timeout  out  1  sticky error flag.
- stall_cycle_count  out  COUNTER_WIDTH  saturating count of cycles with fetch_stall=1.

Behaviour:
- States: RUN, MEM_WAIT, MULDIV_BUSY. Control outputs are combinational from state and inputs. State, counters and flags are registered.
- Reset (synchronous): state becomes RUN; busy_count, wait_count, muldiv_release and memory_timeout become 0; stall_cycle_count becomes 0. While reset is high, all control outputs are forced to 0.
- Memory freeze (top priority, any state except MULDIV_BUSY): memory_access_request=1 and memory_access_ready=0.
  - Outputs: fetch/decode/execute/memory_stall=1 and writeback_bubble=1; every other output is 0.
  - State goes to MEM_WAIT. It returns to RUN in the cycle ready=1; that cycle carries no freeze.
- Memory timeout: wait_count increments each MEM_WAIT cycle and clears on exit. When it reaches MEM_TIMEOUT, memory_timeout sets and stays set until reset. The pipeline keeps waiting.
- Mul/div issue (RUN, no freeze, execute_muldiv_start=1, muldiv_release=0):
  - Outputs: fetch/decode/execute_stall=1 and memory_bubble=1.
  - busy_count is loaded with MULDIV_LATENCY-2; state goes to MULDIV_BUSY.
- MULDIV_BUSY:
  - Outputs are the same as at issue.
  - busy_count decrements each cycle. When busy_count==1 the state goes to RUN and muldiv_release is set.
  - Total stall is MULDIV_LATENCY-1 cycles; the instruction advances on cycle MULDIV_LATENCY.
  - execute_muldiv_start and memory_access_request are ignored while in this state.
- muldiv_release: set for exactly one RUN cycle. It masks the still-asserted execute_muldiv_start so the same instruction is not re-issued.
- Branch redirect (RUN, no freeze, no issue, execute_branch_taken=1): decode_flush=1 and execute_bubble=1, same cycle. No stalls.
- Load-use hazard (RUN, no freeze, no branch):
  - Condition: execute_is_load=1, execute_destination_register_number≠0, and a match on (number_a with read_a) or (number_b with read_b).
  - Outputs: fetch_stall=1, decode_stall=1, execute_bubble=1 for one cycle. The stall is not repeated because execute then holds a bubble.
- Branch, load and mul/div are mutually exclusive properties of the execute instruction. If more than one is asserted, the priority is: freeze > issue > branch > load-use.
- stall_cycle_count: increments when fetch_stall=1 and saturates at all-ones.

Decomposition:
- Shared header hazard_defs.vh contains:
  - state encodings: RUN=2'd0, MEM_WAIT=2'd1, MULDIV_BUSY=2'd2;
  - the NOP encoding 32'h00000013.
- One combinational sub-module, load_use_detector, takes the decode and execute register fields and returns the hazard bit.
- The FSM, counters and output priority mux stay in hazard_controller.

Test Plan:
- Load x5 in execute, decode reads rs2=x5 with read_b=1 → exactly one cycle of fetch_stall=1, decode_stall=1, execute_bubble=1. Repeat with rd=x0 → no stall.
- memory_access_request=1, ready held 0 for 3 cycles → four stall signals and writeback_bubble high for 3 cycles; release in the cycle ready=1; stall_cycle_count increases by 3.
- MULDIV_LATENCY=4, start held high continuously → execute_stall high for 3 cycles, low on cycle 4 despite start=1 (release mask), memory_bubble high for 3 cycles.
- execute_branch_taken=1 coinciding with a decode load-use match → decode_flush=1 and execute_bubble=1, fetch_stall=0.
- ready held 0 for 70 cycles, MEM_TIMEOUT=64 → memory_timeout rises after 64 wait cycles and stays high after ready returns; a reset pulse clears it.
- reset asserted mid-MULDIV_BUSY (busy_count=1) → next cycle state=RUN, all outputs 0, counters 0, no phantom release mask.
